// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard unit and ID->EX->MEM->WB control pipeline for a 5-stage in-order core.
//   - Holds the registered control bundle, RD and VALID for EX, MEM and WB.
//   - EX also keeps RS1/RS2 for operand forwarding.
//   - Detects load-use hazards (STALL) and redirects (FLUSH), and inserts bubbles into EX.
//   - Picks forwarding sources for both EX operands.
//   - Counts bubbles caused by stalls and flushes.
// Ports
//   CLK, RST            : clock, synchronous active-high reset
//   ID_*                : decode-stage instruction (valid, register fields, control bundle)
//   EX_REDIRECT         : taken branch/jump resolved in EX this cycle
//   EX_*, MEM_*, WB_*   : registered per-stage bundle, RD, VALID (EX adds RS1/RS2)
//   STALL, FLUSH        : combinational front-end hold / IF-ID squash
//   FWD_A, FWD_B        : 00 regfile, 01 MEM result, 10 WB result
//   BUBBLE_CNT          : bubbles inserted into EX by STALL or FLUSH
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_VALID,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic [4:0]  ID_RD,
  input  logic [3:0]  ID_ALUOp,
  input  logic        ID_ALUSrcA,
  input  logic        ID_ALUSrcB,
  input  logic        ID_isJump,
  input  logic        ID_isLoad,
  input  logic [3:0]  ID_D_MEM_BE,
  input  logic        ID_D_MEM_WEN,
  input  logic        ID_D_MemRead,
  input  logic [1:0]  ID_RWSrc,
  input  logic [1:0]  ID_OPSrc,
  input  logic        ID_RF_WE,
  input  logic        EX_REDIRECT,
  output logic        EX_VALID,
  output logic [4:0]  EX_RS1,
  output logic [4:0]  EX_RS2,
  output logic [4:0]  EX_RD,
  output logic [3:0]  EX_ALUOp,
  output logic        EX_ALUSrcA,
  output logic        EX_ALUSrcB,
  output logic        EX_isJump,
  output logic        EX_isLoad,
  output logic [3:0]  EX_D_MEM_BE,
  output logic        EX_D_MEM_WEN,
  output logic        EX_D_MemRead,
  output logic [1:0]  EX_RWSrc,
  output logic [1:0]  EX_OPSrc,
  output logic        EX_RF_WE,
  output logic        MEM_VALID,
  output logic [4:0]  MEM_RD,
  output logic [3:0]  MEM_ALUOp,
  output logic        MEM_ALUSrcA,
  output logic        MEM_ALUSrcB,
  output logic        MEM_isJump,
  output logic        MEM_isLoad,
  output logic [3:0]  MEM_D_MEM_BE,
  output logic        MEM_D_MEM_WEN,
  output logic        MEM_D_MemRead,
  output logic [1:0]  MEM_RWSrc,
  output logic [1:0]  MEM_OPSrc,
  output logic        MEM_RF_WE,
  output logic        WB_VALID,
  output logic [4:0]  WB_RD,
  output logic [3:0]  WB_ALUOp,
  output logic        WB_ALUSrcA,
  output logic        WB_ALUSrcB,
  output logic        WB_isJump,
  output logic        WB_isLoad,
  output logic [3:0]  WB_D_MEM_BE,
  output logic        WB_D_MEM_WEN,
  output logic        WB_D_MemRead,
  output logic [1:0]  WB_RWSrc,
  output logic [1:0]  WB_OPSrc,
  output logic        WB_RF_WE,
  output logic        STALL,
  output logic        FLUSH,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic [31:0] BUBBLE_CNT
);

  // Packed control bundle:
  //   {ALUOp, ALUSrcA, ALUSrcB, isJump, isLoad, BE, WEN, MemRead, RWSrc, OPSrc, RF_WE}
  localparam int BW       = 19;
  localparam int B_IS_LOAD = 11;
  localparam int B_RF_WE   = 0;
  // A bubble has every field cleared except the active-low store enable.
  localparam logic [BW-1:0] BUBBLE = 19'h00040;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  logic [BW-1:0] bnd_reg   [3];
  logic [4:0]    rd_reg    [3];
  logic          valid_reg [3];
  logic [4:0]    ex_rs_reg [2];
  logic [31:0]   bubble_cnt_reg;

  logic [BW-1:0] id_bundle;
  logic          load_use;
  logic          ex_bubble;
  logic [BW-1:0] ex_bnd_next;
  logic [4:0]    ex_rd_next;
  logic          ex_valid_next;
  logic [4:0]    ex_rs1_next;
  logic [4:0]    ex_rs2_next;
  logic [31:0]   bubble_cnt_next;
  logic [1:0]    fwd_sel [2];

  assign id_bundle = {ID_ALUOp, ID_ALUSrcA, ID_ALUSrcB, ID_isJump, ID_isLoad,
                      ID_D_MEM_BE, ID_D_MEM_WEN, ID_D_MemRead, ID_RWSrc,
                      ID_OPSrc, ID_RF_WE};

  // A load in EX whose data the ID instruction needs cannot be forwarded in time.
  assign load_use = ID_VALID && valid_reg[0] && bnd_reg[0][B_IS_LOAD] &&
                    bnd_reg[0][B_RF_WE] && (rd_reg[0] != 5'd0) &&
                    ((rd_reg[0] == ID_RS1) || (rd_reg[0] == ID_RS2));

  // A redirect squashes the ID instruction anyway, so it overrides the stall.
  assign FLUSH = EX_REDIRECT;
  assign STALL = load_use && !EX_REDIRECT;

  assign ex_bubble = STALL || FLUSH || !ID_VALID;

  always_comb begin
    ex_bnd_next   = id_bundle;
    ex_rd_next    = ID_RD;
    ex_valid_next = 1'b1;
    ex_rs1_next   = ID_RS1;
    ex_rs2_next   = ID_RS2;
    if (ex_bubble) begin
      ex_bnd_next   = BUBBLE;
      ex_rd_next    = 5'd0;
      ex_valid_next = 1'b0;
      ex_rs1_next   = 5'd0;
      ex_rs2_next   = 5'd0;
    end
  end

  // Idle decode slots are not hazard bubbles, so they are not counted.
  assign bubble_cnt_next = (STALL || FLUSH) ? bubble_cnt_reg + 32'd1 : bubble_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        bnd_reg[i]   <= BUBBLE;
        rd_reg[i]    <= 5'd0;
        valid_reg[i] <= 1'b0;
      end
      ex_rs_reg[0]   <= 5'd0;
      ex_rs_reg[1]   <= 5'd0;
      bubble_cnt_reg <= 32'd0;
    end else begin
      for (int i = 1; i < 3; i++) begin
        bnd_reg[i]   <= bnd_reg[i-1];
        rd_reg[i]    <= rd_reg[i-1];
        valid_reg[i] <= valid_reg[i-1];
      end
      bnd_reg[0]     <= ex_bnd_next;
      rd_reg[0]      <= ex_rd_next;
      valid_reg[0]   <= ex_valid_next;
      ex_rs_reg[0]   <= ex_rs1_next;
      ex_rs_reg[1]   <= ex_rs2_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  // Forwarding for each EX operand.
  // MEM wins over WB because it is the younger write.
  // A MEM-stage load has no data yet, so it never forwards from MEM.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (valid_reg[1] && bnd_reg[1][B_RF_WE] && !bnd_reg[1][B_IS_LOAD] &&
       (rd_reg[1] != 5'd0) && (rd_reg[1] == ex_rs_reg[gi])) ? 2'b01 :
      (valid_reg[2] && bnd_reg[2][B_RF_WE] &&
       (rd_reg[2] != 5'd0) && (rd_reg[2] == ex_rs_reg[gi])) ? 2'b10 : 2'b00;
  end

  assign FWD_A      = fwd_sel[0];
  assign FWD_B      = fwd_sel[1];
  assign BUBBLE_CNT = bubble_cnt_reg;

  assign EX_VALID  = valid_reg[0];
  assign EX_RD     = rd_reg[0];
  assign EX_RS1    = ex_rs_reg[0];
  assign EX_RS2    = ex_rs_reg[1];
  assign {EX_ALUOp, EX_ALUSrcA, EX_ALUSrcB, EX_isJump, EX_isLoad, EX_D_MEM_BE,
          EX_D_MEM_WEN, EX_D_MemRead, EX_RWSrc, EX_OPSrc, EX_RF_WE} = bnd_reg[0];

  assign MEM_VALID = valid_reg[1];
  assign MEM_RD    = rd_reg[1];
  assign {MEM_ALUOp, MEM_ALUSrcA, MEM_ALUSrcB, MEM_isJump, MEM_isLoad, MEM_D_MEM_BE,
          MEM_D_MEM_WEN, MEM_D_MemRead, MEM_RWSrc, MEM_OPSrc, MEM_RF_WE} = bnd_reg[1];

  assign WB_VALID  = valid_reg[2];
  assign WB_RD     = rd_reg[2];
  assign {WB_ALUOp, WB_ALUSrcA, WB_ALUSrcB, WB_isJump, WB_isLoad, WB_D_MEM_BE,
          WB_D_MEM_WEN, WB_D_MemRead, WB_RWSrc, WB_OPSrc, WB_RF_WE} = bnd_reg[2];

endmodule
